arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-way, W-bit output-registered multiplexer with a valid/ready handshake on every input and on the output. It has two selection modes: fixed select, and round-robin arbitration among valid inputs. It generalises the team's combinational 4:1 and 16:1 muxes to any power-of-two channel count and data width. Its intended use is funnelling multiple producers, such as memory-mapped peripherals and writeback sources, into one registered consumer port.

## Interface
- WIDTH, 32: data width per channel.
- NUM_IN, 16: channel count; power of two, 2..16.
- SEL_W, $clog2(NUM_IN): select/index width; derived, not overridden.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- mode  in  1  0 = fixed select via sel; 1 = round-robin among valid inputs.
- sel  in  SEL_W  channel index used when mode=0.
- in_valid  in  NUM_IN  per-channel valid; bit i belongs to channel i.
- in_data  in  NUM_IN*WIDTH  flattened; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  out  NUM_IN  per-channel accept strobe; at most one bit high.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

## Operation
- Internal state:
  - Output register: out_valid, out_data, out_sel.
  - Round-robin pointer ptr, SEL_W bits.
- Load condition: load = !out_valid || out_ready.
- Eligibility:
  - mode=0: only channel sel is eligible, and only if in_valid[sel]=1.
  - mode=1: every channel with in_valid=1 is eligible. Priority starts at ptr and ascends modulo NUM_IN.
- Grant g is the first eligible channel. There is no grant if no channel is eligible.
- in_ready[i] = load && (a grant exists) && (g == i). All other in_ready bits are 0.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a clock edge with load=1:
  - Grant exists: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - No grant: out_valid <= 0. out_data and out_sel hold.
- On a clock edge with load=0: all output registers hold. This is backpressure, and no in_ready is asserted.
- Pointer update: ptr <= (g+1) mod NUM_IN, only on a mode=1 transfer. ptr wraps from NUM_IN-1 to 0. ptr is untouched in mode=0.
- Mode or sel changes:
  - Take effect in the same cycle for eligibility.
  - Never alter a word already held in the output register.
- Combinational paths:
  - in_ready depends combinationally on in_valid, sel, mode, and out_ready.
  - Producers must not make in_valid depend on in_ready.
  - A producer, once valid, keeps data stable until it transfers. This is not checked.

## Timing
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Throughput: one word per cycle while out_ready=1 and any input is eligible.
- Reset (resetn low, asynchronous, takes effect immediately without waiting for a clock edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready=0 whenever resetn is low.
- Deassertion of resetn is synchronous to the design's clock. The first grant is possible on the first edge after deassertion.
- Simultaneous out_ready=1 and a new grant: the old word is consumed and the new word loaded on the same edge, with no bubble.
- All channels valid in mode=1: strict rotation 0,1,…,NUM_IN-1,0.
- Reset mid-transfer: the held word is discarded; nothing is replayed.

## Test plan
- Reset: drive resetn=0 between edges with out_valid=1.
  - Required: out_valid, out_data, and out_sel go to 0 immediately; in_ready=0x0000.
  - After release, ptr=0 (the first mode=1 grant with all channels valid is channel 0).
- Fixed select: mode=0, sel=5, in_valid=0xFFFF, channel 5 data 0xA5A50005, out_ready=1.
  - Required: in_ready=0x0020.
  - Next cycle: out_valid=1, out_data=0xA5A50005, out_sel=5.
- Round-robin streaming: mode=1, all 16 channels valid with data 0x100+i, out_ready=1 for 20 cycles.
  - Required: out_sel sequence 0..15 then 0,1,2,3, with data matching; one transfer per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles.
  - Required: out_data and out_sel held; in_ready=0 throughout.
  - On release: old word consumed, next granted word loaded on the same edge.
- Round-robin skip and wrap: mode=1, only channels 3 and 12 valid.
  - Required: grants alternate 3, 12, 3, 12.
  - ptr reads 4 after granting 3 and 13 after granting 12; wraps past 15 to 0.
- Idle and mode switch: in_valid=0 with out_ready=1.
  - Required: out_valid drops to 0 next cycle.
  - Switching mode 1→0 with sel=7 while out_valid=1 leaves the held word unchanged; the next grant comes only from channel 7.

Source files
------------

// File: rtl/arb_mux.sv
// N-way, W-bit output-registered multiplexer with valid/ready on every port.
// Selects a channel by fixed index (mode=0) or round-robin among valid inputs (mode=1).
module arb_mux #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    i_clock,
    input  logic                    i_resetn,
    input  logic                    i_mode,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [NUM_IN-1:0]       i_in_valid,
    input  logic [NUM_IN*WIDTH-1:0] i_in_data,
    output logic [NUM_IN-1:0]       o_in_ready,
    output logic                    o_out_valid,
    output logic [WIDTH-1:0]        o_out_data,
    output logic [SEL_W-1:0]        o_out_sel,
    input  logic                    i_out_ready
);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic [SEL_W-1:0]   r_ptr;

    logic [WIDTH-1:0]   w_chan_data [NUM_IN];
    logic               w_load;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_grant_found;
    logic [SEL_W-1:0]   w_grant_idx;
    logic               w_transfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign w_chan_data[gi] = i_in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_load = !r_out_valid || i_out_ready;

    // Scan from the highest offset down so the lowest offset from r_ptr wins;
    // NUM_IN is a power of two, so the SEL_W-bit sum wraps modulo NUM_IN.
    always_comb begin
        logic [SEL_W-1:0] w_cand;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_cand = r_ptr + SEL_W'(k);
            if (i_in_valid[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    assign w_grant_found = i_mode ? w_rr_found : i_in_valid[i_sel];
    assign w_grant_idx   = i_mode ? w_rr_idx   : i_sel;
    assign w_transfer    = i_resetn && w_load && w_grant_found;

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign o_in_ready[gi] = w_transfer && (w_grant_idx == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load) begin
                if (w_grant_found) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_chan_data[w_grant_idx];
                    r_out_sel   <= w_grant_idx;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (i_mode && w_transfer) begin
                r_ptr <= w_grant_idx + SEL_W'(1);
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: expected words queued at grant time, checked when they appear.
module tb_arb_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 16;
    localparam int SEL_W  = 4;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .i_clock    (clk),
        .i_resetn   (resetn),
        .i_mode     (mode),
        .i_sel      (sel),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_out_valid(out_valid),
        .o_out_data (out_data),
        .o_out_sel  (out_sel),
        .i_out_ready(out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data;
        for (int i = 0; i < NUM_IN; i++)
            in_data[i*WIDTH +: WIDTH] = WIDTH'(32'h100 + i);
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset;
        logic [SEL_W+WIDTH-1:0] e;
        mode = 1'b0; sel = 4'd2; in_valid = 16'hFFFF; out_ready = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        tests_run++;
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data got=%h want=0", out_data); end
        tests_run++;
        if (out_sel !== 4'd0) begin tests_failed++; $display("FAIL reset_sel got=%0d want=0", out_sel); end
        tests_run++;
        if (in_ready !== 16'h0) begin tests_failed++; $display("FAIL reset_ready got=%h want=0000", in_ready); end
        @(negedge clk);
        resetn = 1'b1; mode = 1'b1; out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 16'h0001) begin tests_failed++; $display("FAIL reset_first_ready got=%h want=0001", in_ready); end
        exp_q.push_back({4'd0, 32'h100});
        tick();
        tests_run++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL reset_first_word valid=%0b queue=%0d", out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL reset_first_word got=%0d/%h want=%0d/%h", out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
            else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
        end
    endtask

    task automatic test_fixed_select;
        logic [SEL_W+WIDTH-1:0] e;
        mode = 1'b0; sel = 4'd5; in_valid = 16'hFFFF; out_ready = 1'b1;
        in_data[5*WIDTH +: WIDTH] = 32'hA5A50005;
        #1;
        tests_run++;
        if (in_ready !== 16'h0020) begin tests_failed++; $display("FAIL fixed_ready got=%h want=0020", in_ready); end
        exp_q.push_back({4'd5, 32'hA5A50005});
        tick();
        tests_run++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL fixed_word valid=%0b queue=%0d", out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL fixed_word got=%0d/%h want=%0d/%h", out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
            else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
        end
        set_default_data();
    endtask

    task automatic test_rr_stream;
        logic [SEL_W+WIDTH-1:0] e;
        logic [SEL_W-1:0]       ch;
        logic [NUM_IN-1:0]      want_rdy;
        do_reset();
        mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ch = SEL_W'(c % NUM_IN);
            want_rdy = NUM_IN'(1) << ch;
            #1;
            tests_run++;
            if (in_ready !== want_rdy) begin tests_failed++; $display("FAIL stream_ready c=%0d got=%h want=%h", c, in_ready, want_rdy); end
            exp_q.push_back({ch, WIDTH'(32'h100 + ch)});
            tick();
            tests_run++;
            if (exp_q.size() == 0 || out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL stream_word c=%0d valid=%0b queue=%0d", c, out_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL stream_word c=%0d got=%0d/%h want=%0d/%h", c, out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
                else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [SEL_W+WIDTH-1:0] e;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (in_ready !== 16'h0) begin tests_failed++; $display("FAIL bp_ready c=%0d got=%h want=0000", c, in_ready); end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 4'd3 || out_data !== 32'h103) begin
                tests_failed++; $display("FAIL bp_hold c=%0d got=%0b/%0d/%h want=1/3/00000103", c, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 16'h0010) begin tests_failed++; $display("FAIL bp_release_ready got=%h want=0010", in_ready); end
        exp_q.push_back({4'd4, 32'h104});
        tick();
        tests_run++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL bp_release_word valid=%0b queue=%0d", out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL bp_release_word got=%0d/%h want=%0d/%h", out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
            else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
        end
    endtask

    task automatic test_rr_skip_wrap;
        logic [SEL_W+WIDTH-1:0] e;
        logic [SEL_W-1:0]       exp_g [4];
        logic [SEL_W-1:0]       exp_p [4];
        logic [NUM_IN-1:0]      want_rdy;
        exp_g = '{4'd3, 4'd12, 4'd3, 4'd12};
        exp_p = '{4'd4, 4'd13, 4'd4, 4'd13};
        do_reset();
        mode = 1'b1; in_valid = 16'h1008; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            want_rdy = NUM_IN'(1) << exp_g[c];
            #1;
            tests_run++;
            if (in_ready !== want_rdy) begin tests_failed++; $display("FAIL skip_ready c=%0d got=%h want=%h", c, in_ready, want_rdy); end
            exp_q.push_back({exp_g[c], WIDTH'(32'h100 + exp_g[c])});
            tick();
            tests_run++;
            if (exp_q.size() == 0 || out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL skip_word c=%0d valid=%0b queue=%0d", c, out_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL skip_word c=%0d got=%0d/%h want=%0d/%h", c, out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
                else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
            end
            tests_run++;
            if (dut.r_ptr !== exp_p[c]) begin tests_failed++; $display("FAIL skip_ptr c=%0d got=%0d want=%0d", c, dut.r_ptr, exp_p[c]); end
        end
    endtask

    task automatic test_idle_mode_switch;
        logic [SEL_W+WIDTH-1:0] e;
        in_valid = 16'h0; out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 16'h0) begin tests_failed++; $display("FAIL idle_ready got=%h want=0000", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_sel !== 4'd12 || out_data !== 32'h10C) begin
            tests_failed++; $display("FAIL idle_drop got=%0b/%0d/%h want=0/12/0000010c", out_valid, out_sel, out_data);
        end
        in_valid = 16'hFFFF;
        #1;
        tests_run++;
        if (in_ready !== 16'h2000) begin tests_failed++; $display("FAIL idle_resume_ready got=%h want=2000", in_ready); end
        exp_q.push_back({4'd13, 32'h10D});
        tick();
        tests_run++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL idle_resume_word valid=%0b queue=%0d", out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL idle_resume_word got=%0d/%h want=%0d/%h", out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
            else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
        end
        out_ready = 1'b0; mode = 1'b0; sel = 4'd7;
        #1;
        tests_run++;
        if (in_ready !== 16'h0) begin tests_failed++; $display("FAIL switch_ready got=%h want=0000", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_sel !== 4'd13 || out_data !== 32'h10D) begin
            tests_failed++; $display("FAIL switch_hold got=%0b/%0d/%h want=1/13/0000010d", out_valid, out_sel, out_data);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 16'h0080) begin tests_failed++; $display("FAIL switch_ready7 got=%h want=0080", in_ready); end
        exp_q.push_back({4'd7, 32'h107});
        tick();
        tests_run++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL switch_word valid=%0b queue=%0d", out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({out_sel, out_data} !== e) begin tests_failed++; $display("FAIL switch_word got=%0d/%h want=%0d/%h", out_sel, out_data, e[WIDTH+:SEL_W], e[WIDTH-1:0]); end
            else $display("[TB] xfer sel=%0d data=%h", out_sel, out_data);
        end
        tests_run++;
        if (dut.r_ptr !== 4'd14) begin tests_failed++; $display("FAIL switch_ptr got=%0d want=14", dut.r_ptr); end
        in_valid = 16'hFF7F;
        #1;
        tests_run++;
        if (in_ready !== 16'h0) begin tests_failed++; $display("FAIL switch_only7_ready got=%h want=0000", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL switch_only7_valid got=%0b want=0", out_valid); end
    endtask

    initial begin
        resetn = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
        set_default_data();
        do_reset();
        test_reset();
        test_fixed_select();
        test_rr_stream();
        test_backpressure();
        test_rr_skip_wrap();
        test_idle_mode_switch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
